// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM register info in, stall/forward controls out.
// Pure wiring, no latency of its own.
// Pipeline side (master) drives stage info; controller (slave) drives interlock outputs.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             use_rs;
  logic             use_rt;
  logic             ewreg;
  logic             em2reg;
  logic [4:0]       ern;
  logic             mwreg;
  logic             mm2reg;
  logic [4:0]       mrn;
  logic             md_start;
  logic             md_read;
  logic             stall_clr;
  logic             wpcir;
  logic             ebubble;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs, rt, use_rs, use_rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn,
           md_start, md_read, stall_clr,
    input  wpcir, ebubble, fwda, fwdb, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  rs, rt, use_rs, use_rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn,
           md_start, md_read, stall_clr,
    output wpcir, ebubble, fwda, fwdb, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Interlock/forwarding controller: load-use and HI/LO stalls, ID forwarding selects, mult/div busy sequencer, stall counter.
// wpcir/ebubble/fwda/fwdb are combinational; md_busy/md_done/stall_cnt are registered (busy for MD_LAT cycles, done one cycle later).
// Backpressure: wpcir=0 freezes PC and IF/ID while ebubble drains ID/EX; a stalled md_start is simply re-presented.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 8,   // 2..16, total cycles the HI/LO unit stays occupied
  parameter int CNT_W  = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             md_done_q, md_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             loaduse;
  logic             md_busy;
  logic             md_stall;
  logic             wpcir;

  // EX result beats MEM; register 0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       e_wreg,
    input logic       e_m2reg,
    input logic [4:0] e_rn,
    input logic       m_wreg,
    input logic       m_m2reg,
    input logic [4:0] m_rn
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (e_wreg && !e_m2reg && (e_rn != 5'd0) && (e_rn == src)) begin
      sel = 2'b01;
    end else if (m_wreg && !m_m2reg && (m_rn != 5'd0) && (m_rn == src)) begin
      sel = 2'b10;
    end else if (m_wreg && m_m2reg && (m_rn != 5'd0) && (m_rn == src)) begin
      sel = 2'b11;
    end
    return sel;
  endfunction

  // Stall decision: a load in EX feeding ID, or any HI/LO access while the unit is occupied.
  always_comb begin
    md_busy  = (state_q == BUSY);
    loaduse  = hz.ewreg && hz.em2reg && (hz.ern != 5'd0) &&
               ((hz.use_rs && (hz.ern == hz.rs)) || (hz.use_rt && (hz.ern == hz.rt)));
    md_stall = md_busy && (hz.md_start || hz.md_read);
    wpcir    = !(loaduse || md_stall);
  end

  // Mult/div sequencer next state; a start is only taken when ID actually advances.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (hz.md_start && wpcir) begin
          state_d = BUSY;
          cnt_d   = 4'(MD_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d   = IDLE;
          md_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall counter next value: clear wins, otherwise count frozen cycles and stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz.stall_clr) begin
      stall_cnt_d = '0;
    end else if (!wpcir && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      md_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      md_done_q   <= md_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.wpcir     = wpcir;
  assign hz.ebubble   = !wpcir;
  assign hz.fwda      = fwd_sel(hz.rs, hz.ewreg, hz.em2reg, hz.ern, hz.mwreg, hz.mm2reg, hz.mrn);
  assign hz.fwdb      = fwd_sel(hz.rt, hz.ewreg, hz.em2reg, hz.ern, hz.mwreg, hz.mm2reg, hz.mrn);
  assign hz.md_busy   = md_busy;
  assign hz.md_done   = md_done_q;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a cycle-indexed reference model.
// Instance A: MD_LAT=8, CNT_W=32 (main checks). Instance B: MD_LAT=3, CNT_W=4 (saturation, short latency).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_pipe_hazard_ctrl;
  localparam int LAT_A = 8;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) hza();
  pipe_hazard_ctrl_if #(.CNT_W(4))  hzb();

  pipe_hazard_ctrl #(.MD_LAT(LAT_A), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .hz(hza.slave));
  pipe_hazard_ctrl #(.MD_LAT(LAT_B), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .hz(hzb.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for instance A: an operation accepted in cycle s is busy in
  // cycles s+1..s+LAT_A and signals done in cycle s+LAT_A+1.
  int          cyc;
  int          busy_lo, busy_hi;
  int          done_q[$];
  logic [31:0] exp_cnt;

  function automatic bit m_loaduse();
    return hza.ewreg && hza.em2reg && hza.ern != 0 &&
           ((hza.use_rs && hza.ern == hza.rs) || (hza.use_rt && hza.ern == hza.rt));
  endfunction

  function automatic bit m_busy();
    return (cyc >= busy_lo) && (cyc <= busy_hi);
  endfunction

  function automatic bit m_done();
    foreach (done_q[i]) if (done_q[i] == cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_wpcir();
    return !(m_loaduse() || (m_busy() && (hza.md_start || hza.md_read)));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (r == 0) return 2'b00;
    if (hza.ewreg && !hza.em2reg && hza.ern == r) return 2'b01;
    if (hza.mwreg && hza.mrn == r) return hza.mm2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    cyc = 0; busy_lo = 1; busy_hi = 0; done_q = {}; exp_cnt = '0;
  endtask

  task automatic clear_inputs();
    hza.rs = 0; hza.rt = 0; hza.use_rs = 0; hza.use_rt = 0; hza.ewreg = 0; hza.em2reg = 0;
    hza.ern = 0; hza.mwreg = 0; hza.mm2reg = 0; hza.mrn = 0; hza.md_start = 0; hza.md_read = 0;
    hza.stall_clr = 0;
    hzb.rs = 0; hzb.rt = 0; hzb.use_rs = 0; hzb.use_rt = 0; hzb.ewreg = 0; hzb.em2reg = 0;
    hzb.ern = 0; hzb.mwreg = 0; hzb.mm2reg = 0; hzb.mrn = 0; hzb.md_start = 0; hzb.md_read = 0;
    hzb.stall_clr = 0;
  endtask

  // Advance one clock: the model consumes the current inputs, then we land on the next falling edge.
  task automatic step();
    bit w, acc;
    w   = m_wpcir();
    acc = hza.md_start && w && !m_busy();
    if (hza.stall_clr) exp_cnt = '0;
    else if (!w && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
    if (acc) begin
      busy_lo = cyc + 1; busy_hi = cyc + LAT_A; done_q.push_back(cyc + LAT_A + 1);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (hza.wpcir !== 1'b1)      begin n_bad++; $display("FAIL reset_wpcir got=%0b exp=1", hza.wpcir); end
    n_cmp++; if (hza.ebubble !== 1'b0)    begin n_bad++; $display("FAIL reset_ebubble got=%0b exp=0", hza.ebubble); end
    n_cmp++; if (hza.fwda !== 2'b00)      begin n_bad++; $display("FAIL reset_fwda got=%b exp=00", hza.fwda); end
    n_cmp++; if (hza.fwdb !== 2'b00)      begin n_bad++; $display("FAIL reset_fwdb got=%b exp=00", hza.fwdb); end
    n_cmp++; if (hza.md_busy !== 1'b0)    begin n_bad++; $display("FAIL reset_md_busy got=%0b exp=0", hza.md_busy); end
    n_cmp++; if (hza.md_done !== 1'b0)    begin n_bad++; $display("FAIL reset_md_done got=%0b exp=0", hza.md_done); end
    n_cmp++; if (hza.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", hza.stall_cnt); end
    n_cmp++; if (hzb.stall_cnt !== 4'd0)  begin n_bad++; $display("FAIL reset_stall_cnt_b got=%0d exp=0", hzb.stall_cnt); end
    do_reset();
  endtask

  task automatic test_loaduse();
    hza.ewreg = 1; hza.em2reg = 1; hza.ern = 5; hza.rs = 5; hza.use_rs = 1;
    #1;
    n_cmp++; if (hza.wpcir !== 1'b0)   begin n_bad++; $display("FAIL lu_rs_wpcir got=%0b exp=0", hza.wpcir); end
    n_cmp++; if (hza.ebubble !== 1'b1) begin n_bad++; $display("FAIL lu_rs_ebubble got=%0b exp=1", hza.ebubble); end
    step();
    clear_inputs(); #1;
    n_cmp++; if (hza.stall_cnt !== 32'd1) begin n_bad++; $display("FAIL lu_rs_cnt got=%0d exp=1", hza.stall_cnt); end
    hza.ewreg = 1; hza.em2reg = 1; hza.ern = 0; hza.rs = 0; hza.use_rs = 1;
    #1;
    n_cmp++; if (hza.wpcir !== 1'b1) begin n_bad++; $display("FAIL lu_r0_wpcir got=%0b exp=1", hza.wpcir); end
    step();
    n_cmp++; if (hza.stall_cnt !== 32'd1) begin n_bad++; $display("FAIL lu_r0_cnt got=%0d exp=1", hza.stall_cnt); end
    clear_inputs();
    hza.ewreg = 1; hza.em2reg = 1; hza.ern = 7; hza.rt = 7; hza.use_rt = 1;
    #1;
    n_cmp++; if (hza.wpcir !== 1'b0) begin n_bad++; $display("FAIL lu_rt_wpcir got=%0b exp=0", hza.wpcir); end
    hza.use_rt = 0; #1;
    n_cmp++; if (hza.wpcir !== 1'b1) begin n_bad++; $display("FAIL lu_rt_unused_wpcir got=%0b exp=1", hza.wpcir); end
    clear_inputs();
  endtask

  task automatic test_forward();
    hza.rs = 3; hza.rt = 3; hza.ewreg = 1; hza.ern = 3; hza.mwreg = 1; hza.mrn = 3;
    #1;
    n_cmp++; if (hza.fwda !== 2'b01) begin n_bad++; $display("FAIL fwd_ex_a got=%b exp=01", hza.fwda); end
    n_cmp++; if (hza.fwdb !== 2'b01) begin n_bad++; $display("FAIL fwd_ex_b got=%b exp=01", hza.fwdb); end
    hza.ewreg = 0; #1;
    n_cmp++; if (hza.fwda !== 2'b10) begin n_bad++; $display("FAIL fwd_mem_a got=%b exp=10", hza.fwda); end
    n_cmp++; if (hza.fwdb !== 2'b10) begin n_bad++; $display("FAIL fwd_mem_b got=%b exp=10", hza.fwdb); end
    hza.mm2reg = 1; #1;
    n_cmp++; if (hza.fwda !== 2'b11) begin n_bad++; $display("FAIL fwd_load_a got=%b exp=11", hza.fwda); end
    n_cmp++; if (hza.fwdb !== 2'b11) begin n_bad++; $display("FAIL fwd_load_b got=%b exp=11", hza.fwdb); end
    hza.rs = 0; hza.rt = 9; hza.ewreg = 1; hza.ern = 0; hza.mrn = 0; #1;
    n_cmp++; if (hza.fwda !== 2'b00) begin n_bad++; $display("FAIL fwd_r0_a got=%b exp=00", hza.fwda); end
    n_cmp++; if (hza.fwdb !== 2'b00) begin n_bad++; $display("FAIL fwd_nomatch_b got=%b exp=00", hza.fwdb); end
    clear_inputs();
  endtask

  task automatic test_md_seq();
    logic [31:0] c0;
    c0 = hza.stall_cnt;
    hza.md_start = 1; #1;
    step();
    hza.md_start = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) hza.md_read = 1;
      if (k == 10) hza.md_read = 0;
      #1;
      n_cmp++; if (hza.md_busy !== (k <= LAT_A)) begin n_bad++; $display("FAIL md_busy k=%0d got=%0b exp=%0b", k, hza.md_busy, k <= LAT_A); end
      n_cmp++; if (hza.md_done !== (k == LAT_A + 1)) begin n_bad++; $display("FAIL md_done k=%0d got=%0b exp=%0b", k, hza.md_done, k == LAT_A + 1); end
      n_cmp++; if (hza.wpcir !== !(k >= 4 && k <= LAT_A)) begin n_bad++; $display("FAIL md_read_wpcir k=%0d got=%0b", k, hza.wpcir); end
      step();
    end
    n_cmp++; if (hza.stall_cnt - c0 !== 32'd5) begin n_bad++; $display("FAIL md_read_stalls got=%0d exp=5", hza.stall_cnt - c0); end
  endtask

  task automatic test_back_to_back();
    hza.md_start = 1; #1;
    step();
    for (int k = 1; k <= LAT_A + 1; k++) begin
      #1;
      n_cmp++; if (hza.wpcir !== (k == LAT_A + 1)) begin n_bad++; $display("FAIL b2b_wpcir k=%0d got=%0b", k, hza.wpcir); end
      n_cmp++; if (hza.md_busy !== m_busy()) begin n_bad++; $display("FAIL b2b_busy k=%0d got=%0b exp=%0b", k, hza.md_busy, m_busy()); end
      n_cmp++; if (hza.md_done !== m_done()) begin n_bad++; $display("FAIL b2b_done k=%0d got=%0b exp=%0b", k, hza.md_done, m_done()); end
      step();
    end
    hza.md_start = 0; #1;
    n_cmp++; if (hza.md_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart got=%0b exp=1", hza.md_busy); end
    for (int i = 0; i < 20 && hza.md_busy; i++) step();
    step();
    n_cmp++; if (hza.md_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_drain timeout busy=%0b", hza.md_busy); end
  endtask

  task automatic test_md_loaduse();
    hza.md_start = 1; hza.ewreg = 1; hza.em2reg = 1; hza.ern = 4; hza.rs = 4; hza.use_rs = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (hza.wpcir !== 1'b0) begin n_bad++; $display("FAIL mdlu_wpcir k=%0d got=%0b exp=0", k, hza.wpcir); end
      step();
      n_cmp++; if (hza.md_busy !== 1'b0) begin n_bad++; $display("FAIL mdlu_busy k=%0d got=%0b exp=0", k, hza.md_busy); end
    end
    hza.ewreg = 0; hza.em2reg = 0; #1;
    n_cmp++; if (hza.wpcir !== 1'b1) begin n_bad++; $display("FAIL mdlu_release got=%0b exp=1", hza.wpcir); end
    step();
    hza.md_start = 0; #1;
    n_cmp++; if (hza.md_busy !== 1'b1) begin n_bad++; $display("FAIL mdlu_accept got=%0b exp=1", hza.md_busy); end
    clear_inputs();
    for (int i = 0; i < 20 && hza.md_busy; i++) step();
    step();
    n_cmp++; if (hza.md_busy !== 1'b0) begin n_bad++; $display("FAIL mdlu_drain timeout busy=%0b", hza.md_busy); end
  endtask

  task automatic test_saturate();
    hzb.ewreg = 1; hzb.em2reg = 1; hzb.ern = 9; hzb.rt = 9; hzb.use_rt = 1;
    for (int n = 1; n <= 20; n++) begin
      step(); #1;
      n_cmp++; if (hzb.stall_cnt !== 4'((n < 15) ? n : 15)) begin n_bad++; $display("FAIL sat n=%0d got=%0d exp=%0d", n, hzb.stall_cnt, (n < 15) ? n : 15); end
    end
    hzb.stall_clr = 1; step(); #1;
    n_cmp++; if (hzb.stall_cnt !== 4'd0) begin n_bad++; $display("FAIL sat_clr got=%0d exp=0", hzb.stall_cnt); end
    hzb.stall_clr = 0; step(); #1;
    n_cmp++; if (hzb.stall_cnt !== 4'd1) begin n_bad++; $display("FAIL sat_after_clr got=%0d exp=1", hzb.stall_cnt); end
    clear_inputs();
    hzb.md_start = 1; #1; step(); hzb.md_start = 0;
    for (int k = 1; k <= LAT_B + 2; k++) begin
      #1;
      n_cmp++; if (hzb.md_busy !== (k <= LAT_B)) begin n_bad++; $display("FAIL lat_b_busy k=%0d got=%0b", k, hzb.md_busy); end
      n_cmp++; if (hzb.md_done !== (k == LAT_B + 1)) begin n_bad++; $display("FAIL lat_b_done k=%0d got=%0b", k, hzb.md_done); end
      step();
    end
  endtask

  task automatic test_reset_mid_busy();
    hza.md_start = 1; #1; step(); hza.md_start = 0;
    repeat (3) step();
    rst_n = 1'b0; #1;
    n_cmp++; if (hza.md_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got=%0b exp=0", hza.md_busy); end
    for (int k = 0; k < LAT_A; k++) begin
      if (k == 2) rst_n = 1'b1;
      step(); #1;
      n_cmp++; if (hza.md_done !== 1'b0 || hza.md_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done k=%0d done=%0b busy=%0b exp=0", k, hza.md_done, hza.md_busy); end
    end
    n_cmp++; if (hza.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", hza.stall_cnt); end
    model_clear();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      hza.rs = 5'($urandom_range(0, 3)); hza.rt = 5'($urandom_range(0, 3));
      hza.use_rs = 1'($urandom); hza.use_rt = 1'($urandom);
      hza.ewreg = 1'($urandom); hza.em2reg = ($urandom_range(0, 3) == 0);
      hza.ern = 5'($urandom_range(0, 3));
      hza.mwreg = 1'($urandom); hza.mm2reg = 1'($urandom); hza.mrn = 5'($urandom_range(0, 3));
      hza.md_start = ($urandom_range(0, 7) == 0); hza.md_read = ($urandom_range(0, 5) == 0);
      hza.stall_clr = ($urandom_range(0, 40) == 0);
      #1;
      n_cmp++; if (hza.wpcir !== m_wpcir()) begin n_bad++; $display("FAIL rnd_wpcir n=%0d got=%0b exp=%0b", n, hza.wpcir, m_wpcir()); end
      n_cmp++; if (hza.ebubble !== !m_wpcir()) begin n_bad++; $display("FAIL rnd_ebubble n=%0d got=%0b exp=%0b", n, hza.ebubble, !m_wpcir()); end
      n_cmp++; if (hza.fwda !== m_fwd(hza.rs)) begin n_bad++; $display("FAIL rnd_fwda n=%0d got=%b exp=%b", n, hza.fwda, m_fwd(hza.rs)); end
      n_cmp++; if (hza.fwdb !== m_fwd(hza.rt)) begin n_bad++; $display("FAIL rnd_fwdb n=%0d got=%b exp=%b", n, hza.fwdb, m_fwd(hza.rt)); end
      n_cmp++; if (hza.md_busy !== m_busy()) begin n_bad++; $display("FAIL rnd_busy n=%0d got=%0b exp=%0b", n, hza.md_busy, m_busy()); end
      n_cmp++; if (hza.md_done !== m_done()) begin n_bad++; $display("FAIL rnd_done n=%0d got=%0b exp=%0b", n, hza.md_done, m_done()); end
      n_cmp++; if (hza.stall_cnt !== exp_cnt) begin n_bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, hza.stall_cnt, exp_cnt); end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_loaduse();
    test_forward();
    test_md_seq();
    test_back_to_back();
    test_md_loaduse();
    test_saturate();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Interlock and forwarding controller for the 5-stage pipeline.
- Produces wpcir, the shared enable for the PC register and the IF/ID register; wpcir=0 freezes both.
- Produces ebubble, which clears the ID/EX control bits, and the ID-stage forwarding selects.
- Owns the multi-cycle multiply/divide busy sequencer and a stall-cycle performance counter.

Parameters:
- MD_LAT, 8, total cycles a mult/div occupies the HI/LO unit (range 2..16).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs  input  5  ID-stage source register rs.
- rt  input  5  ID-stage source register rt.
- use_rs  input  1  ID instruction reads rs.
- use_rt  input  1  ID instruction reads rt.
- ewreg  input  1  EX-stage instruction writes the register file.
- em2reg  input  1  EX-stage instruction is a load.
- ern  input  5  EX-stage destination register.
- mwreg  input  1  MEM-stage instruction writes the register file.
- mm2reg  input  1  MEM-stage instruction is a load.
- mrn  input  5  MEM-stage destination register.
- md_start  input  1  ID instruction is mult/multu/div/divu.
- md_read  input  1  ID instruction is mfhi/mflo/mthi/mtlo.
- stall_clr  input  1  synchronous clear of stall_cnt.
- wpcir  output  1  1 = advance PC and IF/ID; 0 = hold.
- ebubble  output  1  1 = inject a bubble into ID/EX.
- fwda  output  2  operand-A source select.
- fwdb  output  2  operand-B source select.
- md_busy  output  1  HI/LO unit is occupied.
- md_done  output  1  one-cycle pulse when the mult/div completes.
- stall_cnt  output  CNT_W  number of cycles in which wpcir was 0.

Behaviour:
- loaduse = ewreg & em2reg & (ern!=0) & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- md_stall = md_busy & (md_start | md_read).
- wpcir = ~(loaduse | md_stall), combinational. ebubble = ~wpcir.
- fwda selection, first match wins:
  - 01 if ewreg & ~em2reg & ern!=0 & ern==rs (EX ALU result).
  - else 10 if mwreg & ~mm2reg & mrn!=0 & mrn==rs (MEM ALU result).
  - else 11 if mwreg & mm2reg & mrn!=0 & mrn==rs (MEM load data).
  - else 00 (register file).
- fwdb follows the same rules with rt.
- EX priority over MEM is mandatory. Register 0 is never forwarded.
- MD state machine, states IDLE and BUSY, with a 4-bit down-counter cnt:
  - IDLE: if md_start & wpcir, load cnt=MD_LAT-1 and go to BUSY. Otherwise stay.
  - BUSY: if cnt==0, go to IDLE and assert md_done for exactly the next cycle. Otherwise decrement cnt.
  - md_busy = (state==BUSY), registered. Total busy cycles equal MD_LAT.
  - md_start while wpcir=0 because of loaduse is not accepted; it is re-presented when the stall releases.
  - md_start in the cycle BUSY exits to IDLE is stalled, because md_busy is still 1. It is accepted the following cycle.
- stall_cnt:
  - Increments by 1 on each rising edge where wpcir=0.
  - Saturates at all-ones and never wraps.
  - stall_clr has priority over increment and forces 0.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0, md_busy=0, md_done=0, stall_cnt=0.
  - Combinational outputs track inputs; with all inputs 0, wpcir=1, ebubble=0, fwda=fwdb=00.
  - Reset asserted mid-BUSY aborts the operation immediately, with no md_done pulse.
- Simultaneous loaduse and md_stall give a single stall cycle, counted once.

Test Plan:
- Reset with all inputs 0 -> wpcir=1, ebubble=0, fwda=fwdb=00, md_busy=0, stall_cnt=0.
- ewreg=1, em2reg=1, ern=5, rs=5, use_rs=1 for one cycle -> wpcir=0, ebubble=1, stall_cnt goes 0->1. Repeat with ern=0 -> no stall.
- Forward priority: ewreg=1, ern=3, mwreg=1, mrn=3, rs=3, both stages non-load -> fwda=01. Drop ewreg -> fwda=10. Set mm2reg=1 -> fwda=11. Same checks for rt/fwdb.
- MD_LAT=8: md_start pulse at cycle T -> md_busy=1 for cycles T+1..T+8, md_done=1 only at T+9. md_read at T+4 -> wpcir=0 until md_busy falls, stall_cnt increases by 5.
- md_start together with loaduse -> not accepted, md_busy stays 0. Accepted on the first cycle loaduse clears.
- stall_cnt preset near all-ones (CNT_W=4 build) with wpcir held 0 -> saturates at 15. stall_clr=1 with wpcir=0 -> 0. rst_n pulsed mid-BUSY -> md_busy=0, no md_done.
